// File: rtl/frame_tx_sched.sv
// Two-requester frame scheduler: round-robin grant, serial payload to the CRC
// datapath, FCS forwarded from the CRC datapath onto the line, then an inter-frame gap.
`timescale 1us/1ns
module frame_tx_sched #(
   parameter int unsigned PAYLOAD_BITS = 80,
   parameter int unsigned FCS_BITS     = 16,
   parameter int unsigned GAP_CYCLES   = 4,
   parameter int unsigned FCS_TIMEOUT  = 3
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    req0,
   input  logic                    req1,
   input  logic [PAYLOAD_BITS-1:0] data0,
   input  logic [PAYLOAD_BITS-1:0] data1,
   output logic                    gnt0,
   output logic                    gnt1,
   output logic                    crc_data,
   output logic                    crc_data_valid,
   input  logic                    crc_out,
   input  logic                    crc_out_valid,
   output logic                    tx_bit,
   output logic                    tx_bit_valid,
   output logic                    tx_src,
   output logic                    busy,
   output logic                    fcs_err
);

   localparam int unsigned M1 = (PAYLOAD_BITS > FCS_BITS) ? PAYLOAD_BITS : FCS_BITS;
   localparam int unsigned M2 = (M1 > GAP_CYCLES) ? M1 : GAP_CYCLES;
   localparam int unsigned M3 = (M2 > FCS_TIMEOUT) ? M2 : FCS_TIMEOUT;
   localparam int unsigned CW = $clog2(M3 + 1);

   typedef enum logic [2:0] {IDLE, LOAD, SEND, FCS_WAIT, FCS, GAP} state_t;

   state_t                  state_q;
   logic [CW-1:0]           cnt_q;
   logic [PAYLOAD_BITS-1:0] sh_q;
   logic                    last_q;
   logic                    gnt0_q, gnt1_q, cd_q, cdv_q, tb_q, tbv_q, src_q, busy_q, err_q;
   logic                    win_d;

   // Tie goes to the requester that did not win last time.
   always_comb begin
      win_d = req1;
      if (req0 && req1) win_d = ~last_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         last_q  <= 1'b1;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         cd_q    <= 1'b0;
         cdv_q   <= 1'b0;
         tb_q    <= 1'b0;
         tbv_q   <= 1'b0;
         src_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         gnt0_q <= 1'b0;
         gnt1_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req0 || req1) begin
                  state_q <= LOAD;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  gnt0_q  <= ~win_d;
                  gnt1_q  <= win_d;
                  src_q   <= win_d;
                  last_q  <= win_d;
                  sh_q    <= win_d ? data1 : data0;
               end
            end
            LOAD: begin
               state_q <= SEND;
               cnt_q   <= '0;
               cd_q    <= sh_q[PAYLOAD_BITS-1];
               tb_q    <= sh_q[PAYLOAD_BITS-1];
               cdv_q   <= 1'b1;
               tbv_q   <= 1'b1;
               sh_q    <= sh_q << 1;
            end
            SEND: begin
               if (cnt_q == CW'(PAYLOAD_BITS - 1)) begin
                  state_q <= FCS_WAIT;
                  cnt_q   <= '0;
                  cd_q    <= 1'b0;
                  tb_q    <= 1'b0;
                  cdv_q   <= 1'b0;
                  tbv_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  cd_q  <= sh_q[PAYLOAD_BITS-1];
                  tb_q  <= sh_q[PAYLOAD_BITS-1];
                  sh_q  <= sh_q << 1;
               end
            end
            FCS_WAIT: begin
               if (crc_out_valid) begin
                  state_q <= FCS;
                  cnt_q   <= '0;
                  tb_q    <= crc_out;
                  tbv_q   <= 1'b1;
               end else if (cnt_q == CW'(FCS_TIMEOUT - 1)) begin
                  state_q <= GAP;
                  cnt_q   <= '0;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            FCS: begin
               // cnt_q indexes the FCS bit currently on the line; the first was taken in FCS_WAIT.
               if (cnt_q == CW'(FCS_BITS - 1)) begin
                  state_q <= GAP;
                  cnt_q   <= '0;
                  tb_q    <= 1'b0;
                  tbv_q   <= 1'b0;
               end else if (crc_out_valid) begin
                  cnt_q <= cnt_q + 1'b1;
                  tb_q  <= crc_out;
               end else begin
                  state_q <= GAP;
                  cnt_q   <= '0;
                  tb_q    <= 1'b0;
                  tbv_q   <= 1'b0;
                  err_q   <= 1'b1;
               end
            end
            GAP: begin
               if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt0           = gnt0_q;
   assign gnt1           = gnt1_q;
   assign crc_data       = cd_q;
   assign crc_data_valid = cdv_q;
   assign tx_bit         = tb_q;
   assign tx_bit_valid   = tbv_q;
   assign tx_src         = src_q;
   assign busy           = busy_q;
   assign fcs_err        = err_q;

endmodule

// File: tb/tb_frame_tx_sched.sv
// Bench for frame_tx_sched: directed frame table, hand-written reset/withdraw
// sequences and random frames checked cycle by cycle against a frame timeline model.
`timescale 1us/1ns
module tb_frame_tx_sched;

   localparam int P = 80;
   localparam int F = 16;
   localparam int G = 4;
   localparam int T = 3;

   logic         clk, reset_n, req0, req1, crc_out, crc_out_valid;
   logic [P-1:0] data0, data1;
   logic         gnt0, gnt1, crc_data, crc_data_valid, tx_bit, tx_bit_valid, tx_src, busy, fcs_err;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   gnt_at = 0;
   int   gnt_prev = 0;
   logic st = 1'b0;
   logic last_m = 1'b1;

   frame_tx_sched #(
      .PAYLOAD_BITS(P),
      .FCS_BITS(F),
      .GAP_CYCLES(G),
      .FCS_TIMEOUT(T)
   ) dut (
      .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1),
      .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
      .crc_data(crc_data), .crc_data_valid(crc_data_valid),
      .crc_out(crc_out), .crc_out_valid(crc_out_valid),
      .tx_bit(tx_bit), .tx_bit_valid(tx_bit_valid), .tx_src(tx_src),
      .busy(busy), .fcs_err(fcs_err)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic         r0, r1;
      logic [P-1:0] d0, d1;
      int           dly, len;
      logic         ew, ee;
      bit           rst, gp, cg;
   } row_t;

   function automatic logic [8:0] pk(logic g0, logic g1, logic cd, logic cdv, logic tb,
                                     logic tbv, logic src, logic bsy, logic err);
      return {g0, g1, cd, cdv, tb, tbv, src, bsy, err};
   endfunction

   task automatic chk(input string tag, input logic [8:0] exp);
      logic [8:0] act;
      act = {gnt0, gnt1, crc_data, crc_data_valid, tx_bit, tx_bit_valid, tx_src, busy, fcs_err};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %b expected %b (gnt0 gnt1 cd cdv tb tbv src busy err)",
                  tag, cyc, act, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic noise();
      crc_out_valid = 1'($urandom_range(0, 1));
      crc_out       = 1'($urandom_range(0, 1));
   endtask

   // CRC datapath model: FCS bit idx is presented while 0 <= idx < len.
   task automatic drive_fcs(input int idx, input int len, input logic [31:0] fb);
      if (idx >= 0 && idx < len) begin
         crc_out_valid = 1'b1;
         crc_out       = fb[idx];
      end else begin
         crc_out_valid = 1'b0;
         crc_out       = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; crc_out = 1'b0; crc_out_valid = 1'b0;
      #1 chk("reset", 9'b0);
      step();
      chk("reset_hold", 9'b0);
      reset_n = 1'b1;
      st = 1'b0;
      last_m = 1'b1;
   endtask

   // Entered at an IDLE cycle; returns at the following IDLE cycle.
   task automatic frame(input logic nr0, input logic nr1, input logic [P-1:0] d0,
                        input logic [P-1:0] d1, input int dly, input int len,
                        input logic ew, input logic ee, input bit gp);
      logic [P-1:0] pl;
      logic [31:0]  fb;
      int           nw, n;
      bit           tmo;
      fb = $urandom;
      if (nr0 && !req0) data0 = d0;
      if (nr1 && !req1) data1 = d1;
      req0 = req0 | nr0;
      req1 = req1 | nr1;
      pl  = ew ? data1 : data0;
      tmo = (dly >= T) || (len == 0);
      step();
      gnt_prev = gnt_at;
      gnt_at   = cyc;
      chk("load", pk(!ew, ew, 1'b0, 1'b0, 1'b0, 1'b0, ew, 1'b1, st));
      if (ew) req1 = 1'b0; else req0 = 1'b0;
      for (int i = 0; i < P; i++) begin
         noise();
         step();
         chk("send", pk(1'b0, 1'b0, pl[P-1-i], 1'b1, pl[P-1-i], 1'b1, ew, 1'b1, st));
      end
      noise();
      step();
      nw = tmo ? T : dly + 1;
      for (int j = 0; j < nw; j++) begin
         chk("fcs_wait", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ew, 1'b1, st));
         drive_fcs(j - dly, len, fb);
         step();
      end
      if (!tmo) begin
         n = (len < F) ? len : F;
         for (int m = 0; m < n; m++) begin
            chk("fcs", pk(1'b0, 1'b0, 1'b0, 1'b0, fb[m], 1'b1, ew, 1'b1, st));
            drive_fcs(m + 1, len, fb);
            step();
         end
      end
      st = ee;
      for (int g = 0; g < G; g++) begin
         chk("gap", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ew, 1'b1, st));
         noise();
         if (gp) req1 = 1'b1;
         step();
      end
      chk("idle", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ew, 1'b0, st));
      crc_out_valid = 1'b0;
      crc_out       = 1'b0;
      if (gp) req1 = 1'b0;
   endtask

   row_t         tbl[6];
   logic [P-1:0] rd0, rd1;
   logic         nr0, nr1, p0, p1, w, ee;
   int           dly, len;

   initial begin
      reset_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; crc_out = 1'b0; crc_out_valid = 1'b0;
      data0 = '0; data1 = '0;

      tbl[0] = '{1'b1, 1'b0, 80'h1, 80'h0, 0, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 80'hA5A5_0F0F_1234_5678_9ABC, 80'hFFFF_0000_C3C3_8001_7E7E,
                 0, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[2] = '{1'b0, 1'b1, 80'h0, 80'h8000_0000_0000_0000_0001, 0, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{1'b0, 1'b0, 80'h0, 80'h0, 1, 10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 80'hDEAD_BEEF_0123_4567_89AB, 80'h0, 5, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 80'h5555_AAAA_5555_AAAA_5555, 80'h0, 2, 20, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

      #10 chk("reset_async", 9'b0);
      step();
      chk("reset_hold", 9'b0);
      reset_n = 1'b1;

      for (int r = 0; r < 6; r++) begin
         if (tbl[r].rst) do_reset();
         frame(tbl[r].r0, tbl[r].r1, tbl[r].d0, tbl[r].d1, tbl[r].dly, tbl[r].len,
               tbl[r].ew, tbl[r].ee, 1'b0 | tbl[r].gp);
         if (tbl[r].cg) chk_int("gnt_gap", gnt_at - gnt_prev, 1 + P + 1 + F + G + 1);
         if (tbl[r].gp) begin
            for (int k = 0; k < 5; k++) begin
               step();
               chk("withdrawn", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tbl[r].ew, 1'b0, st));
            end
         end
      end

      // Reset in the middle of the payload, then confirm nothing restarts on its own.
      data0 = 80'h0123_4567_89AB_CDEF_FFFF;
      req0  = 1'b1;
      step();
      chk("mr_load", pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, st));
      req0 = 1'b0;
      for (int i = 0; i <= 40; i++) step();
      #20 reset_n = 1'b0;
      #1 chk("mr_async", 9'b0);
      step();
      chk("mr_hold", 9'b0);
      reset_n = 1'b1;
      st = 1'b0;
      last_m = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("mr_post", 9'b0);
      end

      for (int it = 0; it < 25; it++) begin
         for (int b = 0; b < P; b++) begin
            rd0[b] = 1'($urandom_range(0, 1));
            rd1[b] = 1'($urandom_range(0, 1));
         end
         nr0 = 1'($urandom_range(0, 1));
         nr1 = 1'($urandom_range(0, 1));
         if (it == 0) begin nr0 = 1'b1; nr1 = 1'b1; end
         if (!(req0 | nr0 | req1 | nr1)) nr0 = 1'b1;
         dly = $urandom_range(0, 4);
         len = ($urandom_range(0, 2) != 0) ? F : $urandom_range(0, 20);
         p0 = req0 | nr0;
         p1 = req1 | nr1;
         w  = (p0 && p1) ? !last_m : p1;
         last_m = w;
         ee = st | (dly >= T) | (len < F);
         frame(nr0, nr1, rd0, rd1, dly, len, w, ee, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
